// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - round-robin serial bit distributor driving an external 8:1 demux
module demux_rr_sched #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_mask,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic [2:0] sel,
    output logic       dmx_i,
    output logic       dmx_valid,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter reload so that the routed bit stays on the demux for DWELL cycles.
    localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [3:0] cnt;
    logic       accept;
    logic       cnt_zero;
    logic [2:0] target;
    logic [2:0] idx;
    logic       found;
    logic [7:0] upper_mask;
    logic       last_chan;

    assign accept   = in_valid && in_ready;
    assign cnt_zero = (cnt == 4'd0);

    // Round-robin search: first enabled channel at or above ptr, wrapping 7 -> 0.
    always_comb begin
        target = 3'd0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && en_mask[idx]) begin
                target = idx;
                found  = 1'b1;
            end
        end
    end

    // The target closes a pass when no enabled channel sits above it.
    always_comb begin
        upper_mask = en_mask & ~((8'd2 << target) - 8'd1);
        last_chan  = (upper_mask == 8'd0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = (en_mask != 8'd0) && !rst;
                if (accept) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Routing datapath: load on accept, count down the dwell, release the demux at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 3'd0;
            cnt        <= 4'd0;
            sel        <= 3'd0;
            dmx_i      <= 1'b0;
            dmx_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (accept) begin
            sel        <= target;
            dmx_i      <= in_bit;
            dmx_valid  <= 1'b1;
            cnt        <= CNT_LOAD;
            ptr        <= target + 3'd1;
            frame_done <= last_chan;
        end else begin
            frame_done <= 1'b0;
            if (state == HOLD) begin
                if (cnt_zero) begin
                    dmx_valid <= 1'b0;
                    dmx_i     <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - self-checking bench for demux_rr_sched at DWELL 1, 3 and 4
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] en_mask = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;

    logic [2:0] rdy;
    logic [2:0] dv;
    logic [2:0] fd;
    logic [2:0] bz;
    logic [2:0] di;
    logic [2:0] sl [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_rr_sched #(.DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .en_mask(en_mask), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(rdy[0]), .sel(sl[0]), .dmx_i(di[0]), .dmx_valid(dv[0]),
        .frame_done(fd[0]), .busy(bz[0])
    );

    demux_rr_sched #(.DWELL(3)) u_d3 (
        .clk(clk), .rst(rst), .en_mask(en_mask), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(rdy[1]), .sel(sl[1]), .dmx_i(di[1]), .dmx_valid(dv[1]),
        .frame_done(fd[1]), .busy(bz[1])
    );

    demux_rr_sched #(.DWELL(4)) u_d4 (
        .clk(clk), .rst(rst), .en_mask(en_mask), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(rdy[2]), .sel(sl[2]), .dmx_i(di[2]), .dmx_valid(dv[2]),
        .frame_done(fd[2]), .busy(bz[2])
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one bit and hold it until the selected DUT accepts; returns at the negedge after the accept.
    task automatic send_bit(input int d, input logic b, output logic ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_bit = b;
        for (int t = 0; t < 64; t++) begin
            #1;
            if (rdy[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout dut=%0d in_ready=%b required=1", d, rdy[d]);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en_mask = 8'hFF;
        in_valid = 1'b1;
        in_bit = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", rdy[0]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sl[0], di[0], dv[0], fd[0], bz[0]} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs sel=%0d dmx_i=%b valid=%b fd=%b busy=%b exp all 0",
                     sl[0], di[0], dv[0], fd[0], bz[0]);
        end
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_sweep_ff();
        logic ok;
        logic b;
        do_reset();
        en_mask = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            b = (k % 2 == 0);
            send_bit(0, b, ok);
            if (ok) begin
                checks++;
                if (sl[0] !== 3'(k % 8) || di[0] !== b || dv[0] !== 1'b1 || fd[0] !== (k % 8 == 7)) begin
                    failures++;
                    $display("FAIL sweep_ff k=%0d sel=%0d dmx_i=%b valid=%b fd=%b exp sel=%0d dmx_i=%b valid=1 fd=%b",
                             k, sl[0], di[0], dv[0], fd[0], k % 8, b, (k % 8 == 7));
                end
            end
        end
    endtask

    task automatic test_pair_mask();
        logic ok;
        logic [2:0] exp_sel;
        do_reset();
        en_mask = 8'h24;
        for (int k = 0; k < 4; k++) begin
            exp_sel = (k % 2 == 0) ? 3'd2 : 3'd5;
            send_bit(0, 1'(k), ok);
            if (ok) begin
                checks++;
                if (sl[0] !== exp_sel || fd[0] !== (exp_sel == 3'd5)) begin
                    failures++;
                    $display("FAIL pair_mask k=%0d sel=%0d fd=%b exp sel=%0d fd=%b",
                             k, sl[0], fd[0], exp_sel, (exp_sel == 3'd5));
                end
            end
        end
    endtask

    task automatic test_mask_zero();
        do_reset();
        en_mask = 8'h00;
        in_valid = 1'b1;
        in_bit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (rdy[0] !== 1'b0 || dv[0] !== 1'b0 || bz[0] !== 1'b0) begin
                failures++;
                $display("FAIL mask_zero cyc=%0d ready=%b valid=%b busy=%b exp 0 0 0", k, rdy[0], dv[0], bz[0]);
            end
            @(negedge clk);
        end
        en_mask = 8'h01;
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL mask_zero_release ready=%b exp=1", rdy[0]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (sl[0] !== 3'd0 || fd[0] !== 1'b1 || dv[0] !== 1'b1) begin
            failures++;
            $display("FAIL mask_zero_accept sel=%0d fd=%b valid=%b exp 0 1 1", sl[0], fd[0], dv[0]);
        end
    endtask

    task automatic test_mask_change_in_hold();
        logic ok;
        do_reset();
        en_mask = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            send_bit(0, 1'b1, ok);
        end
        en_mask = 8'h01;
        #1;
        checks++;
        if (sl[0] !== 3'd3 || dv[0] !== 1'b1 || bz[0] !== 1'b1 || di[0] !== 1'b1) begin
            failures++;
            $display("FAIL mask_change_hold sel=%0d valid=%b busy=%b dmx_i=%b exp 3 1 1 1", sl[0], dv[0], bz[0], di[0]);
        end
        @(negedge clk);
        checks++;
        if (sl[0] !== 3'd3 || dv[0] !== 1'b0 || di[0] !== 1'b0) begin
            failures++;
            $display("FAIL mask_change_release sel=%0d valid=%b dmx_i=%b exp 3 0 0", sl[0], dv[0], di[0]);
        end
        send_bit(0, 1'b0, ok);
        if (ok) begin
            checks++;
            if (sl[0] !== 3'd0 || fd[0] !== 1'b1) begin
                failures++;
                $display("FAIL mask_change_next sel=%0d fd=%b exp 0 1", sl[0], fd[0]);
            end
        end
    endtask

    task automatic test_dwell3_timing();
        logic exp_v;
        logic exp_r;
        do_reset();
        en_mask = 8'hFF;
        in_valid = 1'b1;
        in_bit = 1'b1;
        #1;
        checks++;
        if (rdy[1] !== 1'b1) begin
            failures++;
            $display("FAIL dwell3_ready_start ready=%b exp=1", rdy[1]);
        end
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_v = (k != 3);
            exp_r = (k == 3);
            checks++;
            if (dv[1] !== exp_v || rdy[1] !== exp_r || bz[1] !== exp_v) begin
                failures++;
                $display("FAIL dwell3_edge N+%0d valid=%b ready=%b busy=%b exp %b %b %b",
                         k, dv[1], rdy[1], bz[1], exp_v, exp_r, exp_v);
            end
        end
        checks++;
        if (sl[1] !== 3'd1) begin
            failures++;
            $display("FAIL dwell3_second_sel got=%0d exp=1", sl[1]);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        logic ok;
        do_reset();
        en_mask = 8'h30;
        send_bit(2, 1'b1, ok);
        checks++;
        if (sl[2] !== 3'd4 || fd[2] !== 1'b0 || dv[2] !== 1'b1) begin
            failures++;
            $display("FAIL rst_hold_first sel=%0d fd=%b valid=%b exp 4 0 1", sl[2], fd[2], dv[2]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dv[2] !== 1'b0 || sl[2] !== 3'd0 || bz[2] !== 1'b0 || di[2] !== 1'b0) begin
            failures++;
            $display("FAIL rst_hold_abort valid=%b sel=%0d busy=%b dmx_i=%b exp 0 0 0 0", dv[2], sl[2], bz[2], di[2]);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (fd[2] !== 1'b0 || dv[2] !== 1'b0) begin
                failures++;
                $display("FAIL rst_hold_quiet cyc=%0d fd=%b valid=%b exp 0 0", k, fd[2], dv[2]);
            end
        end
        send_bit(2, 1'b0, ok);
        if (ok) begin
            checks++;
            if (sl[2] !== 3'd4 || dv[2] !== 1'b1) begin
                failures++;
                $display("FAIL rst_hold_next sel=%0d valid=%b exp 4 1", sl[2], dv[2]);
            end
        end
    endtask

    // Transaction-level reference: remaining dwell cycles plus a round-robin start point.
    task automatic test_random(input int d, input int dwell);
        int   m_ptr;
        int   m_rem;
        int   m_sel;
        logic m_bit;
        logic m_fd;
        logic exp_rdy;
        logic exp_di;
        int   t;
        do_reset();
        m_ptr = 0;
        m_rem = 0;
        m_sel = 0;
        m_bit = 1'b0;
        m_fd  = 1'b0;
        en_mask = 8'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_di = (m_rem > 0) ? m_bit : 1'b0;
            checks++;
            if (dv[d] !== (m_rem > 0) || bz[d] !== (m_rem > 0) || sl[d] !== 3'(m_sel) ||
                di[d] !== exp_di || fd[d] !== m_fd) begin
                failures++;
                $display("FAIL random_out dut=%0d cyc=%0d valid=%b busy=%b sel=%0d dmx_i=%b fd=%b exp %b %b %0d %b %b",
                         d, cyc, dv[d], bz[d], sl[d], di[d], fd[d], (m_rem > 0), (m_rem > 0), m_sel, exp_di, m_fd);
            end
            rst = ($urandom % 50 == 0);
            if ($urandom % 4 == 0) begin
                en_mask = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
            end
            in_valid = ($urandom % 3 != 0);
            in_bit = 1'($urandom);
            #1;
            exp_rdy = !rst && (m_rem == 0) && (en_mask != 8'h00);
            checks++;
            if (rdy[d] !== exp_rdy) begin
                failures++;
                $display("FAIL random_ready dut=%0d cyc=%0d got=%b exp=%b", d, cyc, rdy[d], exp_rdy);
            end
            if (rst) begin
                m_ptr = 0;
                m_rem = 0;
                m_sel = 0;
                m_bit = 1'b0;
                m_fd  = 1'b0;
            end else if (in_valid && exp_rdy) begin
                t = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (en_mask[(m_ptr + i) % 8]) t = (m_ptr + i) % 8;
                end
                m_sel = t;
                m_bit = in_bit;
                m_rem = dwell;
                m_fd  = ((int'(en_mask) >> (t + 1)) == 0);
                m_ptr = (t + 1) % 8;
            end else begin
                m_fd = 1'b0;
                if (m_rem > 0) m_rem--;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep_ff();
        test_pair_mask();
        test_mask_zero();
        test_mask_change_in_hold();
        test_dwell3_timing();
        test_reset_mid_hold();
        test_random(0, 1);
        test_random(1, 3);
        test_random(2, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
